// File: rtl/cross_bar_drr_scheduler_mx1.sv
// Deficit-round-robin output scheduler for one crossbar output port.
// Shares a single AXI-Stream master among CHANNEL_NO input channels at
// packet granularity. Each visited channel is credited a quantum of beats.
// A head packet is forwarded only while the channel's deficit covers its
// advertised length. The channel is charged for the beats actually sent.

module cross_bar_drr_scheduler_mx1_chk #(
  parameter int CHANNEL_NO = 4
) (
  input logic                  aclk,
  input logic                  aresetn,
  input logic                  grant_active,
  input logic                  m_axis_tvalid,
  input logic [CHANNEL_NO-1:0] tready_vec
);

  // The output never shows a beat unless a packet is granted.
  a_idle_quiet: assert property (@(posedge aclk) disable iff (!aresetn)
    !grant_active |-> !m_axis_tvalid);

  // At most one input channel is ever offered tready.
  a_ready_onehot: assert property (@(posedge aclk) disable iff (!aresetn)
    $onehot0(tready_vec));

  // An input tready is only raised for the granted channel.
  a_ready_owner: assert property (@(posedge aclk) disable iff (!aresetn)
    (tready_vec != '0) |-> grant_active);

endmodule

module cross_bar_drr_scheduler_mx1 #(
  parameter int MSEL_WIDTH = 2,
  parameter int CHANNEL_NO = 2**MSEL_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata  [CHANNEL_NO],
  input  logic                  s_axis_tvalid [CHANNEL_NO],
  input  logic                  s_axis_tlast  [CHANNEL_NO],
  input  logic [CNT_WIDTH-1:0]  s_axis_plen   [CHANNEL_NO],
  output logic                  s_axis_tready [CHANNEL_NO],
  input  logic [CNT_WIDTH-1:0]  quantum       [CHANNEL_NO],
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [MSEL_WIDTH-1:0] grant_ch,
  output logic                  grant_active
);

  typedef enum logic [1:0] {
    ST_VISIT  = 2'd0,
    ST_CHECK  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MSEL_WIDTH-1:0] PTR_ONE  = {{(MSEL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MSEL_WIDTH-1:0] PTR_LAST = MSEL_WIDTH'(CHANNEL_NO - 1);

  // Credit a quantum, clamping at the counter ceiling instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [CNT_WIDTH-1:0] b
  );
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[CNT_WIDTH]) begin
      sat_add = CNT_MAX;
    end else begin
      sat_add = sum[CNT_WIDTH-1:0];
    end
  endfunction

  // Charge beats_done+1 (the tlast beat is counted here) and floor at zero.
  function automatic logic [CNT_WIDTH-1:0] charge_floor(
    input logic [CNT_WIDTH-1:0] deficit,
    input logic [CNT_WIDTH-1:0] beats_done
  );
    logic [CNT_WIDTH:0] charge;
    charge = {1'b0, beats_done} + {{CNT_WIDTH{1'b0}}, 1'b1};
    if ({1'b0, deficit} > charge) begin
      charge_floor = deficit - charge[CNT_WIDTH-1:0];
    end else begin
      charge_floor = {CNT_WIDTH{1'b0}};
    end
  endfunction

  // Beat counter increment that sticks at its ceiling.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] a
  );
    if (a == CNT_MAX) begin
      sat_inc = CNT_MAX;
    end else begin
      sat_inc = a + CNT_ONE;
    end
  endfunction

  state_t                state_r;
  state_t                state_nxt_s;
  logic [MSEL_WIDTH-1:0] ptr_r;
  logic [MSEL_WIDTH-1:0] ptr_nxt_s;
  logic [MSEL_WIDTH-1:0] ptr_inc_s;
  logic [CNT_WIDTH-1:0]  deficit_r [CHANNEL_NO];
  logic [CNT_WIDTH-1:0]  beats_r;
  logic [CNT_WIDTH-1:0]  beats_nxt_s;
  logic                  def_we_s;
  logic [CNT_WIDTH-1:0]  def_wdata_s;

  logic                  sel_valid_s;
  logic                  sel_last_s;
  logic [CNT_WIDTH-1:0]  sel_plen_s;
  logic [CNT_WIDTH-1:0]  sel_deficit_s;
  logic [CNT_WIDTH-1:0]  sel_quantum_s;
  logic [CNT_WIDTH-1:0]  eff_len_s;
  logic                  eligible_s;
  logic                  handshake_s;
  logic [CHANNEL_NO-1:0] tready_vec_s;

  // Pick out the pointed-to channel and derive eligibility and handshake.
  always_comb begin
    sel_valid_s   = s_axis_tvalid[ptr_r];
    sel_last_s    = s_axis_tlast[ptr_r];
    sel_plen_s    = s_axis_plen[ptr_r];
    sel_deficit_s = deficit_r[ptr_r];
    sel_quantum_s = quantum[ptr_r];
    // A zero-length advertisement still occupies at least one beat.
    eff_len_s     = (sel_plen_s == {CNT_WIDTH{1'b0}}) ? CNT_ONE : sel_plen_s;
    eligible_s    = sel_valid_s && (eff_len_s <= sel_deficit_s);
    handshake_s   = (state_r == ST_ACTIVE) && sel_valid_s && m_axis_tready;
    ptr_inc_s     = (ptr_r == PTR_LAST) ? {MSEL_WIDTH{1'b0}} : (ptr_r + PTR_ONE);
  end

  // Scheduler state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_VISIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: visit -> check -> forward, holding the packet lock until tlast.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_VISIT: begin
        if (sel_valid_s) begin
          state_nxt_s = ST_CHECK;
        end else begin
          state_nxt_s = ST_VISIT;
        end
      end
      ST_CHECK: begin
        if (eligible_s) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_VISIT;
        end
      end
      ST_ACTIVE: begin
        if (handshake_s && sel_last_s) begin
          state_nxt_s = ST_CHECK;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s = ST_VISIT;
      end
    endcase
  end

  // Pointer, deficit and beat-counter updates that accompany each state.
  always_comb begin
    ptr_nxt_s   = ptr_r;
    beats_nxt_s = beats_r;
    def_we_s    = 1'b0;
    def_wdata_s = sel_deficit_s;
    case (state_r)
      ST_VISIT: begin
        def_we_s = 1'b1;
        if (sel_valid_s) begin
          def_wdata_s = sat_add(sel_deficit_s, sel_quantum_s);
        end else begin
          // An empty channel forfeits any banked credit.
          def_wdata_s = {CNT_WIDTH{1'b0}};
          ptr_nxt_s   = ptr_inc_s;
        end
      end
      ST_CHECK: begin
        if (eligible_s) begin
          beats_nxt_s = {CNT_WIDTH{1'b0}};
        end else begin
          // A too-long packet keeps its credit; an emptied queue loses it.
          if (!sel_valid_s) begin
            def_we_s    = 1'b1;
            def_wdata_s = {CNT_WIDTH{1'b0}};
          end else begin
            def_we_s    = 1'b0;
          end
          ptr_nxt_s = ptr_inc_s;
        end
      end
      ST_ACTIVE: begin
        if (handshake_s) begin
          beats_nxt_s = sat_inc(beats_r);
          if (sel_last_s) begin
            def_we_s    = 1'b1;
            def_wdata_s = charge_floor(sel_deficit_s, beats_r);
          end else begin
            def_we_s    = 1'b0;
          end
        end else begin
          beats_nxt_s = beats_r;
        end
      end
      default: begin
        ptr_nxt_s = ptr_r;
      end
    endcase
  end

  // Round-robin pointer and per-packet beat counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_r   <= {MSEL_WIDTH{1'b0}};
      beats_r <= {CNT_WIDTH{1'b0}};
    end else begin
      ptr_r   <= ptr_nxt_s;
      beats_r <= beats_nxt_s;
    end
  end

  // Per-channel deficit counters; only the pointed-to entry is ever written.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < CHANNEL_NO; i++) begin
        deficit_r[i] <= {CNT_WIDTH{1'b0}};
      end
    end else if (def_we_s) begin
      deficit_r[ptr_r] <= def_wdata_s;
    end
  end

  // Output mux: the granted channel drives the master only while forwarding.
  always_comb begin
    for (int i = 0; i < CHANNEL_NO; i++) begin
      s_axis_tready[i] = 1'b0;
      tready_vec_s[i]  = 1'b0;
    end
    if (state_r == ST_ACTIVE) begin
      m_axis_tdata  = s_axis_tdata[ptr_r];
      m_axis_tvalid = sel_valid_s;
      m_axis_tlast  = sel_last_s;
      for (int i = 0; i < CHANNEL_NO; i++) begin
        s_axis_tready[i] = (ptr_r == MSEL_WIDTH'(i)) && m_axis_tready;
        tready_vec_s[i]  = (ptr_r == MSEL_WIDTH'(i)) && m_axis_tready;
      end
    end else begin
      m_axis_tdata  = {DATA_WIDTH{1'b0}};
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
    end
    grant_ch     = ptr_r;
    grant_active = (state_r == ST_ACTIVE);
  end

  cross_bar_drr_scheduler_mx1_chk #(
    .CHANNEL_NO (CHANNEL_NO)
  ) u_chk (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .grant_active  (grant_active),
    .m_axis_tvalid (m_axis_tvalid),
    .tready_vec    (tready_vec_s)
  );

endmodule

// File: tb/tb_cross_bar_drr_scheduler_mx1.sv
// Directed bench for the DRR output scheduler: per-channel packet queues act
// as upstream FIFOs, every output handshake is logged with its cycle number,
// and logs are compared against hand-computed packet order and timing.

module tb_cross_bar_drr_scheduler_mx1;

  localparam int MW = 2;
  localparam int CN = 4;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_tdata  [CN];
  logic          s_tvalid [CN];
  logic          s_tlast  [CN];
  logic [CW-1:0] s_plen   [CN];
  logic          s_tready [CN];
  logic [CW-1:0] quant    [CN];
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [MW-1:0] grant_ch;
  logic          grant_active;

  always #5 aclk = ~aclk;

  cross_bar_drr_scheduler_mx1 #(
    .MSEL_WIDTH (MW),
    .CHANNEL_NO (CN),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_plen   (s_plen),
    .s_axis_tready (s_tready),
    .quantum       (quant),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .grant_ch      (grant_ch),
    .grant_active  (grant_active)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        last;
    logic [1:0]  ch;
  } rec_t;

  // One table entry: quanta, up to two packets per channel (slot a/b),
  // expected packet order as tags {slot,ch}, and first/last handshake cycles.
  typedef struct packed {
    logic [3:0][15:0] quant;
    logic [3:0][7:0]  la;
    logic [3:0][15:0] pa;
    logic [3:0][7:0]  lb;
    logic [3:0][15:0] pb;
    logic [7:0][3:0]  order;
    int               n;
    int               first;
    int               last;
  } scen_t;

  logic [31:0] qd [CN][$];
  bit          ql [CN][$];
  logic [15:0] qp [CN][$];
  rec_t        log_q[$];
  scen_t       sc [6];

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  bit tready_toggle = 1'b0;
  int win_lo = -1;
  int win_hi = -2;
  logic [1:0] win_ch = 2'd0;

  function automatic logic [31:0] dat(input int ch, input int slot, input int b);
    logic [1:0] c;
    logic       s;
    logic [7:0] bb;
    c  = ch[1:0];
    s  = slot[0];
    bb = b[7:0];
    return {8'hD0, 6'd0, c, 4'd0, 3'd0, s, bb};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < CN; i++) begin
      s_tvalid[i] = (qd[i].size() > 0);
      s_tdata[i]  = (qd[i].size() > 0) ? qd[i][0] : 32'd0;
      s_tlast[i]  = (ql[i].size() > 0) ? ql[i][0] : 1'b0;
      s_plen[i]   = (qp[i].size() > 0) ? qp[i][0] : 16'd0;
    end
  endtask

  task automatic push_pkt(input int ch, input int slot, input int len, input logic [15:0] plen);
    for (int b = 0; b < len; b++) begin
      qd[ch].push_back(dat(ch, slot, b));
      ql[ch].push_back(b == len - 1);
    end
    qp[ch].push_back(plen);
    drive();
  endtask

  task automatic clear_all();
    for (int i = 0; i < CN; i++) begin
      qd[i].delete();
      ql[i].delete();
      qp[i].delete();
    end
    log_q.delete();
    drive();
  endtask

  // Sample on the falling edge, then pop handshaken beats just after the rising edge.
  task automatic step();
    bit   pop [CN];
    bit   l;
    rec_t r;
    @(negedge aclk);
    for (int i = 0; i < CN; i++) begin
      pop[i] = s_tvalid[i] && s_tready[i];
      if (!grant_active || i != int'(grant_ch)) check("idle_tready", 64'(s_tready[i]), 64'(1'b0));
    end
    check("idle_mvalid", 64'(m_tvalid && !grant_active), 64'(1'b0));
    if (cycle >= win_lo && cycle <= win_hi)
      check("packet_lock", 64'({grant_active, grant_ch}), 64'({1'b1, win_ch}));
    if (m_tvalid && m_tready) begin
      r.cyc = cycle; r.data = m_tdata; r.last = m_tlast; r.ch = grant_ch;
      log_q.push_back(r);
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < CN; i++) begin
      if (pop[i]) begin
        void'(qd[i].pop_front());
        l = ql[i].pop_front();
        if (l) void'(qp[i].pop_front());
      end
    end
    cycle++;
    if (tready_toggle) m_tready = (cycle % 2 == 0);
    drive();
  endtask

  task automatic begin_scen();
    aresetn = 1'b0;
    m_tready = 1'b1;
    tready_toggle = 1'b0;
    win_lo = -1;
    win_hi = -2;
    clear_all();
  endtask

  // Check reset-state outputs, then release reset just after a rising edge.
  task automatic release_rst();
    @(posedge aclk);
    #1;
    check("rst_mvalid", 64'(m_tvalid), 64'(1'b0));
    check("rst_mlast", 64'(m_tlast), 64'(1'b0));
    check("rst_mdata", 64'(m_tdata), 64'(32'd0));
    check("rst_grant", 64'({grant_active, grant_ch}), 64'(3'd0));
    for (int i = 0; i < CN; i++) check("rst_tready", 64'(s_tready[i]), 64'(1'b0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    cycle = 0;
  endtask

  task automatic verify(input string nm, input int n, input logic [7:0][3:0] order,
                        input logic [3:0][7:0] la, input logic [3:0][7:0] lb,
                        input int first, input int last);
    int idx;
    int total;
    int ch;
    int slot;
    int len;
    total = 0;
    for (int k = 0; k < n; k++) begin
      ch = int'(order[k][1:0]);
      slot = int'(order[k][2]);
      total += (slot != 0) ? int'(lb[ch]) : int'(la[ch]);
    end
    check({nm, "_count"}, 64'(log_q.size()), 64'(total));
    idx = 0;
    for (int k = 0; k < n; k++) begin
      ch = int'(order[k][1:0]);
      slot = int'(order[k][2]);
      len = (slot != 0) ? int'(lb[ch]) : int'(la[ch]);
      for (int b = 0; b < len; b++) begin
        if (idx < log_q.size())
          check({nm, "_beat"}, 64'({log_q[idx].data, log_q[idx].last, log_q[idx].ch}),
                64'({dat(ch, slot, b), (b == len - 1), 2'(ch)}));
        idx++;
      end
    end
    check({nm, "_first"}, 64'((log_q.size() > 0) ? log_q[0].cyc : -1), 64'(first));
    check({nm, "_last"}, 64'((log_q.size() > 0) ? log_q[log_q.size()-1].cyc : -1), 64'(last));
  endtask

  initial begin
    logic [7:0][3:0] ord;
    logic [3:0][7:0] la;
    logic [3:0][7:0] lb;

    aresetn = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < CN; i++) quant[i] = 16'd0;
    clear_all();

    // 0: ch0 and ch2 one 4-beat packet each, ch1/ch3 skipped on the way.
    sc[0] = '0;
    for (int i = 0; i < 4; i++) sc[0].quant[i] = 16'd4;
    sc[0].la[0] = 8'd4; sc[0].pa[0] = 16'd4;
    sc[0].la[2] = 8'd4; sc[0].pa[2] = 16'd4;
    sc[0].order[0] = 4'h0; sc[0].order[1] = 4'h2; sc[0].n = 2;
    sc[0].first = 2; sc[0].last = 13;
    // 1: ch1 6-beat packet needs two rounds of quantum 4.
    sc[1] = '0;
    for (int i = 0; i < 4; i++) sc[1].quant[i] = 16'd4;
    sc[1].la[1] = 8'd6; sc[1].pa[1] = 16'd6;
    sc[1].order[0] = 4'h1; sc[1].n = 1;
    sc[1].first = 8; sc[1].last = 13;
    // 2: quantum 8 covers two 3-beat packets with a one-cycle bubble.
    sc[2] = '0;
    for (int i = 0; i < 4; i++) sc[2].quant[i] = 16'd4;
    sc[2].quant[0] = 16'd8;
    sc[2].la[0] = 8'd3; sc[2].pa[0] = 16'd3;
    sc[2].lb[0] = 8'd3; sc[2].pb[0] = 16'd3;
    sc[2].order[0] = 4'h0; sc[2].order[1] = 4'h4; sc[2].n = 2;
    sc[2].first = 2; sc[2].last = 8;
    // 3: plen=0 counts as 1; overrun charge floors at 0 so the next packet waits a round.
    sc[3] = '0;
    for (int i = 0; i < 4; i++) sc[3].quant[i] = 16'd1;
    sc[3].la[3] = 8'd2; sc[3].pa[3] = 16'd0;
    sc[3].lb[3] = 8'd1; sc[3].pb[3] = 16'd1;
    sc[3].order[0] = 4'h3; sc[3].order[1] = 4'h7; sc[3].n = 2;
    sc[3].first = 5; sc[3].last = 13;
    // 4: all channels busy, strict pointer order.
    sc[4] = '0;
    for (int i = 0; i < 4; i++) begin
      sc[4].quant[i] = 16'd2; sc[4].la[i] = 8'd2; sc[4].pa[i] = 16'd2;
      sc[4].order[i] = 4'(i);
    end
    sc[4].n = 4; sc[4].first = 2; sc[4].last = 18;
    // 5: quantum FFFF saturates; FFFE+FFFF must clamp so the second packet still goes.
    sc[5] = '0;
    sc[5].quant[0] = 16'hFFFF;
    sc[5].la[0] = 8'd1; sc[5].pa[0] = 16'hFFFF;
    sc[5].lb[0] = 8'd1; sc[5].pb[0] = 16'hFFFF;
    sc[5].order[0] = 4'h0; sc[5].order[1] = 4'h4; sc[5].n = 2;
    sc[5].first = 2; sc[5].last = 9;

    for (int s = 0; s < 6; s++) begin
      begin_scen();
      for (int c = 0; c < CN; c++) quant[c] = sc[s].quant[c];
      for (int c = 0; c < CN; c++) begin
        if (sc[s].la[c] != 8'd0) push_pkt(c, 0, int'(sc[s].la[c]), sc[s].pa[c]);
        if (sc[s].lb[c] != 8'd0) push_pkt(c, 1, int'(sc[s].lb[c]), sc[s].pb[c]);
      end
      release_rst();
      repeat (sc[s].last + 4) step();
      verify($sformatf("scen%0d", s), sc[s].n, sc[s].order, sc[s].la, sc[s].lb,
             sc[s].first, sc[s].last);
    end

    // Leftover deficit of 2 must be cleared once ch1 empties: a new 6-beat
    // packet again needs two visits.
    begin_scen();
    for (int c = 0; c < CN; c++) quant[c] = 16'd4;
    push_pkt(1, 0, 6, 16'd6);
    release_rst();
    repeat (16) step();
    push_pkt(1, 1, 6, 16'd6);
    repeat (18) step();
    ord = '0; la = '0; lb = '0;
    ord[0] = 4'h1; ord[1] = 4'h5; la[1] = 8'd6; lb[1] = 8'd6;
    verify("clear", 2, ord, la, lb, 8, 30);
    check("clear_second_start", 64'((log_q.size() > 6) ? log_q[6].cyc : -1), 64'(25));

    // Output backpressure toggling every cycle during a 5-beat packet.
    begin_scen();
    for (int c = 0; c < CN; c++) quant[c] = 16'd8;
    push_pkt(2, 0, 5, 16'd5);
    push_pkt(3, 0, 2, 16'd2);
    tready_toggle = 1'b1;
    win_lo = 4; win_hi = 12; win_ch = 2'd2;
    release_rst();
    repeat (22) step();
    ord = '0; la = '0; lb = '0;
    ord[0] = 4'h2; ord[1] = 4'h3; la[2] = 8'd5; la[3] = 8'd2;
    verify("bp", 2, ord, la, lb, 4, 18);
    check("bp_ch2_last", 64'((log_q.size() > 4) ? log_q[4].cyc : -1), 64'(12));
    tready_toggle = 1'b0;
    win_lo = -1; win_hi = -2;

    // Asynchronous reset on beat 3 of 5, then a fresh start from ptr 0 with zero deficits.
    begin_scen();
    for (int c = 0; c < CN; c++) quant[c] = 16'd8;
    push_pkt(0, 0, 5, 16'd5);
    release_rst();
    repeat (4) step();
    #2;
    check("mid_pre_tvalid", 64'({m_tvalid, m_tdata}), 64'({1'b1, dat(0, 0, 2)}));
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'({m_tvalid, m_tlast}), 64'(2'b00));
    check("mid_rst_tdata", 64'(m_tdata), 64'(32'd0));
    check("mid_rst_grant", 64'({grant_active, grant_ch}), 64'(3'd0));
    check("mid_rst_tready", 64'(s_tready[0]), 64'(1'b0));
    clear_all();
    push_pkt(0, 1, 9, 16'd9);
    release_rst();
    #1;
    check("post_rst_grant", 64'({grant_active, grant_ch}), 64'(3'd0));
    repeat (20) step();
    ord = '0; la = '0; lb = '0;
    ord[0] = 4'h4; lb[0] = 8'd9;
    verify("post_rst", 1, ord, la, lb, 7, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
